mul_div_unit: RTL
=================

# mul_div_unit

Iterative RISC-V M-extension execute unit, the multi-cycle companion to the single-cycle ALU in the EX stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time, computes it one bit per cycle, and returns a tagged result with a one-cycle `done_out` pulse. The hazard logic holds IF/ID/EX while `busy_out` is high. `kill_in` flushes an in-flight operation on a branch or jump redirect.

## Interface
- `XLEN`, 32: operand and result width; any even value ≥ 8.
- `TAG_W`, 5: width of the destination tag carried alongside the operation (rd index).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request to start an operation; accepted only when `ready_out` is 1.
- `funct3_in`  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_in`, `rs2_in`  in  XLEN each  operands (already forwarded).
- `tag_in`  in  TAG_W  destination tag.
- `kill_in`  in  1  abort the current operation.
- `ready_out`  out  1  high in IDLE and DONE.
- `busy_out`  out  1  high in CALC, and in the cycle a start is accepted.
- `done_out`  out  1  one-cycle result-valid pulse.
- `result_out`  out  XLEN  result; held stable until the next accepted start.
- `tag_out`  out  TAG_W  tag of the returned result; held with `result_out`.

## Operation
- States are IDLE, CALC and DONE. The iteration counter is clog2(XLEN)+1 bits wide.
- **Accept.** A start is accepted when `start_in` is 1, `ready_out` is 1 and `kill_in` is 0.
  - The edge latches the operands as magnitudes (sign-stripped per op signedness), the result sign, the funct3 and the tag.
  - The next state is CALC, except for the special cases below.
- **Special cases** (no CALC; next state DONE with the result set on the accept edge):
  - DIV or DIVU with divisor 0: result all ones.
  - REM or REMU with divisor 0: result `rs1_in`.
  - DIV with `rs1_in`=100…0 and `rs2_in`=all ones: result 100…0 (signed overflow).
  - REM with the same operands: result 0.
- **Multiply.** Unsigned shift-add on magnitudes with a 2·XLEN accumulator, one multiplier bit per CALC cycle.
  - Signedness: MULH treats rs1 and rs2 as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - On the final edge, the product is two's-complement negated when the result sign is 1.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- **Divide.** Restoring division on magnitudes, one quotient bit per CALC cycle, MSB first.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - Both signs apply to DIV and REM only; DIVU and REMU are unsigned.
- **Sequencing.**
  - CALC runs exactly XLEN edges, then moves to DONE.
  - DONE lasts one cycle and asserts `done_out`; the next state is IDLE, or CALC or DONE if a new start is accepted in that same cycle.
- **Kill.** `kill_in`=1 in any state forces IDLE at the next edge.
  - It suppresses any `done_out` that edge would produce.
  - It has priority over a simultaneous `start_in`.
  - `result_out` and `tag_out` keep their old values.
- **Reset.** Applies at any edge, including mid-operation, and has priority over `kill_in` and `start_in`.
  - State IDLE, counter 0.
  - `result_out` 0, `tag_out` 0, `done_out` 0, `busy_out` 0, `ready_out` 1.

## Timing
- The start is accepted at edge T.
- Normal operation: CALC occupies edges T+1 … T+XLEN. `done_out`=1 in the cycle following edge T+XLEN, a latency of XLEN+1 cycles (33 for XLEN=32).
- Special cases: `done_out`=1 in the cycle right after edge T (latency 1).
- `result_out` and `tag_out` become valid in the `done_out` cycle and hold until the next accepted start.
- Back-to-back operation: a start accepted during DONE begins immediately, so throughput is one operation per XLEN+1 cycles.
- `busy_out` is combinational: (state==CALC) | (`start_in` & `ready_out` & ~`kill_in`). It holds the pipeline in the same cycle the operation issues.
- `ready_out` and `done_out` depend on registered state only.
- `start_in` in CALC is ignored; no queueing.

## Test plan
- **Signed multiplies** (XLEN=32):
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. `done_out` 33 cycles after the start cycle, `tag_out` = `tag_in`.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
- **Unsigned and mixed multiplies:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - MUL 0 × x → 0.
- **Divides:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/2 → 3; REMU 0xFFFFFFFF/16 → 15.
  - All at latency 33.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Each with `done_out` one cycle after the start.
- **Kill and reset:**
  - `kill_in` 10 cycles into a DIV → no `done_out`, `ready_out`=1 on the next cycle, and a following MUL 3×4 returns 12.
  - `reset` mid-CALC → all outputs at their reset values on the next cycle.
  - `kill_in` and `start_in` in the same cycle → start ignored.
- **Back-to-back:**
  - A start raised in the DONE cycle is accepted; two consecutive DIVU ops complete 33 cycles apart with correct, distinct tags.
  - Repeat the MUL, MULHU and DIV vectors with XLEN=16, where latency is 17.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RISC-V M-extension execute unit. Handles MUL, MULH,
//               MULHSU, MULHU, DIV, DIVU, REM and REMU one at a time, one
//               result bit per cycle, and returns a tagged result together
//               with a single-cycle done pulse.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   start_in    request a new operation (taken only while ready_out is high)
//   funct3_in   M-extension funct3 selecting the operation
//   rs1_in      first operand (already forwarded)
//   rs2_in      second operand (already forwarded)
//   tag_in      destination tag travelling with the operation
//   kill_in     abort whatever is in flight
//   ready_out   unit can take a start this cycle (IDLE or DONE)
//   busy_out    hold request for the front of the pipeline
//   done_out    one-cycle result-valid pulse
//   result_out  result, held until the next completion
//   tag_out     tag belonging to result_out
//
// Revision    : 1.0  initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [2:0]       funct3_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [XLEN-1:0]  result_out,
    output logic [TAG_W-1:0] tag_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               CNT_W      = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  C_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  C_ZERO     = {XLEN{1'b0}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_sign;      // sign to apply to the selected result
    logic [XLEN-1:0]   r_opnd;      // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] r_acc;       // {hi, lo}: product or {remainder, quotient}
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag_out;

    // ------------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic              w_ready;
    logic              w_accept;
    logic              w_last;

    logic              w_rs1_signed;
    logic              w_rs2_signed;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_is_div;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic              w_sign;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN-1:0]   w_spec_result;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_diff;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod_signed;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = start_in && w_ready && !kill_in;
    assign w_last   = (r_state == S_CALC) && (r_cnt == C_LAST_CNT);

    // ------------------------------------------------------------------------
    // Operand decode at accept time: strip signs so the iterative core only
    // ever sees unsigned magnitudes, and remember which sign to restore.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rs1_signed = 1'b0;
        w_rs2_signed = 1'b0;
        case (funct3_in)
            3'b001:  begin w_rs1_signed = 1'b1; w_rs2_signed = 1'b1; end // MULH
            3'b010:  begin w_rs1_signed = 1'b1; w_rs2_signed = 1'b0; end // MULHSU
            3'b100:  begin w_rs1_signed = 1'b1; w_rs2_signed = 1'b1; end // DIV
            3'b110:  begin w_rs1_signed = 1'b1; w_rs2_signed = 1'b1; end // REM
            default: begin w_rs1_signed = 1'b0; w_rs2_signed = 1'b0; end
        endcase
    end

    assign w_neg1 = w_rs1_signed && rs1_in[XLEN-1];
    assign w_neg2 = w_rs2_signed && rs2_in[XLEN-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude.
    assign w_mag1 = w_neg1 ? -rs1_in : rs1_in;
    assign w_mag2 = w_neg2 ? -rs2_in : rs2_in;

    assign w_is_div = funct3_in[2];
    assign w_div0   = w_is_div && (rs2_in == C_ZERO);
    // Signed ops (DIV/REM) have funct3[0] clear.
    assign w_ovf    = w_is_div && !funct3_in[0] &&
                      (rs1_in == C_INT_MIN) && (rs2_in == C_ALL_ONES);
    assign w_special = w_div0 || w_ovf;

    // Remainder takes the dividend sign; product and quotient take the XOR.
    assign w_sign = (w_is_div && funct3_in[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    always_comb begin
        w_spec_result = C_ZERO;
        if (w_div0) begin
            w_spec_result = funct3_in[1] ? rs1_in : C_ALL_ONES;
        end else begin
            w_spec_result = funct3_in[1] ? C_ZERO : C_INT_MIN;
        end
    end

    // ------------------------------------------------------------------------
    // One iteration of the core.
    //   Multiply: r_acc = {partial, multiplier}. Add the multiplicand into the
    //   upper half when the current multiplier LSB is set, then shift right;
    //   the extra sum bit catches the carry.
    //   Divide:   r_acc = {remainder, dividend/quotient}. Shift left by one,
    //   trial-subtract the divisor and shift the quotient bit in at the LSB.
    // ------------------------------------------------------------------------
    assign w_mul_sum = r_acc[0] ? ({1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd})
                                :  {1'b0, r_acc[2*XLEN-1:XLEN]};

    assign w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_opnd});
    // The remainder is always below the divisor, so when the trial succeeds
    // the difference fits in XLEN bits.
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_opnd;

    always_comb begin
        w_step = r_acc;
        if (r_op[2]) begin
            w_step = {(w_qbit ? w_diff : w_rem_sh[XLEN-1:0]),
                      r_acc[XLEN-2:0], w_qbit};
        end else begin
            w_step = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    // Sign restoration and result selection for the final iteration.
    assign w_prod_signed = r_sign ? -w_step : w_step;
    assign w_quot        = r_sign ? -w_step[XLEN-1:0]      : w_step[XLEN-1:0];
    assign w_rem         = r_sign ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = C_ZERO;
        case (r_op)
            3'b000:  w_final = w_prod_signed[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  w_final = w_prod_signed[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  w_final = w_quot;
            default: w_final = w_rem;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A redirect wins over everything except reset.
        if (kill_in) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. busy_out reacts to the issuing start in the same cycle so
    // the hazard logic can stall the front end immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        ready_out = w_ready;
        done_out  = (r_state == S_DONE);
        busy_out  = (r_state == S_CALC) || w_accept;
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= 3'b000;
            r_sign    <= 1'b0;
            r_opnd    <= C_ZERO;
            r_acc     <= '0;
            r_tag     <= '0;
            r_result  <= C_ZERO;
            r_tag_out <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op   <= funct3_in;
            r_sign <= w_sign;
            r_tag  <= tag_in;
            r_opnd <= w_is_div ? w_mag2 : w_mag1;
            r_acc  <= {C_ZERO, (w_is_div ? w_mag1 : w_mag2)};
            if (w_special) begin
                r_result  <= w_spec_result;
                r_tag_out <= tag_in;
            end
        end else if ((r_state == S_CALC) && !kill_in) begin
            r_cnt <= r_cnt + C_CNT_ONE;
            r_acc <= w_step;
            if (w_last) begin
                r_result  <= w_final;
                r_tag_out <= r_tag;
            end
        end
    end

    assign result_out = r_result;
    assign tag_out    = r_tag_out;

endmodule
`default_nettype wire
